// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared opcode constants and PC width for the fetch-side next-PC stage.
package pc_unit_pkg;
   localparam int PC_WIDTH = 16;
   typedef enum logic [3:0] {
      ADD  = 4'h0,
      SUB  = 4'h1,
      BEQ  = 4'h8,
      BNE  = 4'h9,
      JMP  = 4'hA,
      CALL = 4'hB,
      RET  = 4'hC,
      FOR  = 4'hD
   } opcode_e;
   function automatic logic is_ctrl(input logic [3:0] op);
      return op inside {BEQ, BNE, JMP, CALL, RET, FOR};
   endfunction
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: decode-resolver to fetch-PC bundle; master drives the redirect, slave is pc_unit.
interface pc_unit_if
   import pc_unit_pkg::*;
#(parameter int RAS_DEPTH = 8);
   logic                      stall;
   logic                      kill;
   logic [3:0]                op;
   logic [PC_WIDTH-1:0]       id_pc_plus1;
   logic [PC_WIDTH-1:0]       branch_target;
   logic [PC_WIDTH-1:0]       jump_target;
   logic [PC_WIDTH-1:0]       pc;
   logic [PC_WIDTH-1:0]       pc_plus1;
   logic                      flush;
   logic [$clog2(RAS_DEPTH):0] ras_count;
   logic                      ras_overflow;
   logic                      ras_underflow;
   logic                      bad_redirect;
   modport master (output stall, kill, op, id_pc_plus1, branch_target, jump_target,
                   input pc, pc_plus1, flush, ras_count, ras_overflow, ras_underflow, bad_redirect);
   modport slave  (input stall, kill, op, id_pc_plus1, branch_target, jump_target,
                   output pc, pc_plus1, flush, ras_count, ras_overflow, ras_underflow, bad_redirect);
endinterface

// File: rtl/pc_unit_return_stack.sv
// return_stack: circular return-address stack; a push when full overwrites the oldest entry.
module return_stack #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         push_data_i,
   output logic [WIDTH-1:0]         top_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_evt_o,
   output logic                     underflow_evt_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    sp_q, sp_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             full, empty, do_pop;
   assign full            = cnt_q == (AW+1)'(DEPTH);
   assign empty           = cnt_q == '0;
   assign do_pop          = pop_i & ~empty;
   assign top_o           = mem_q[sp_q - AW'(1)];
   assign count_o         = cnt_q;
   assign overflow_evt_o  = push_i & full;
   assign underflow_evt_o = pop_i & empty;
   always_comb begin
      sp_d  = push_i ? sp_q + AW'(1) : do_pop ? sp_q - AW'(1) : sp_q;
      cnt_d = (push_i & ~full) ? cnt_q + (AW+1)'(1) : do_pop ? cnt_q - (AW+1)'(1) : cnt_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sp_q  <= '0;
         cnt_q <= '0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk_i)
      if (push_i & ~rst_i) mem_q[sp_q] <= push_data_i;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register, next-PC select, IF/ID flush and sticky RAS/redirect error flags.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter logic [PC_WIDTH-1:0] RESET_PC  = 16'h0000,
   parameter int                  PC_INC    = 1,
   parameter int                  RAS_DEPTH = 8
) (
   input logic       clk_i,
   input logic       rst_i,
   pc_unit_if.slave  bus
);
   logic [PC_WIDTH-1:0]        pc_q, pc_d, pc_plus1, ras_top;
   logic [$clog2(RAS_DEPTH):0] ras_cnt;
   logic                       redirect, ctrl, flush, push, pop, ovf_evt, unf_evt, is_br, is_jmp;
   logic                       ovf_q, unf_q, bad_q;
   assign pc_plus1 = pc_q + PC_WIDTH'(PC_INC);
   assign redirect = bus.kill & ~bus.stall;
   assign ctrl     = is_ctrl(bus.op);
   assign flush    = redirect & ctrl;
   assign push     = flush & (bus.op == CALL);
   assign pop      = flush & (bus.op == RET);
   assign is_br    = bus.op inside {BEQ, BNE, FOR};
   assign is_jmp   = bus.op inside {JMP, CALL};
   return_stack #(.DEPTH(RAS_DEPTH), .WIDTH(PC_WIDTH)) u_ras (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .push_i         (push),
      .pop_i          (pop),
      .push_data_i    (bus.id_pc_plus1),
      .top_o          (ras_top),
      .count_o        (ras_cnt),
      .overflow_evt_o (ovf_evt),
      .underflow_evt_o(unf_evt)
   );
   // an empty-stack RET falls back to the reset vector
   always_comb
      pc_d = bus.stall ? pc_q
           : !flush    ? pc_plus1
           : is_br     ? bus.branch_target
           : is_jmp    ? bus.jump_target
           : unf_evt   ? RESET_PC
           : ras_top;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q  <= RESET_PC;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         bad_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ovf_q <= ovf_q | ovf_evt;
         unf_q <= unf_q | unf_evt;
         bad_q <= bad_q | (redirect & ~ctrl);
      end
   end
   assign bus.pc            = pc_q;
   assign bus.pc_plus1      = pc_plus1;
   assign bus.flush         = flush;
   assign bus.ras_count     = ras_cnt;
   assign bus.ras_overflow  = ovf_q;
   assign bus.ras_underflow = unf_q;
   assign bus.bad_redirect  = bad_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit sequencing, redirects, RAS wrap/underflow and sticky flags.
module tb_pc_unit;
   import pc_unit_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   pc_unit_if #(.RAS_DEPTH(8)) bus ();
   pc_unit #(.RESET_PC(16'h0000), .PC_INC(1), .RAS_DEPTH(8)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic k, input logic s, input logic [3:0] o);
      bus.kill  = k;
      bus.stall = s;
      bus.op    = o;
      #1;
   endtask
   initial begin
      bus.stall = 0; bus.kill = 0; bus.op = ADD;
      bus.id_pc_plus1 = '0; bus.branch_target = '0; bus.jump_target = '0;
      step();
      rst = 0;
      chk("rst_pc", 32'(bus.pc), 32'h0);
      chk("rst_cnt", 32'(bus.ras_count), 32'h0);
      chk("rst_flags", {29'b0, bus.ras_overflow, bus.ras_underflow, bus.bad_redirect}, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         chk("idle_flush", 32'(bus.flush), 32'h0);
         step();
         chk("idle_pc", 32'(bus.pc), 32'(i));
         chk("idle_cnt", 32'(bus.ras_count), 32'h0);
      end
      bus.jump_target = 16'h0010; drive(1, 0, JMP);
      step();
      chk("jmp10_pc", 32'(bus.pc), 32'h10);
      bus.jump_target = 16'h0040; drive(1, 0, JMP);
      chk("jmp_flush", 32'(bus.flush), 32'h1);
      step();
      chk("jmp_pc", 32'(bus.pc), 32'h40);
      chk("jmp_cnt", 32'(bus.ras_count), 32'h0);
      bus.id_pc_plus1 = 16'h0021; bus.jump_target = 16'h0100; drive(1, 0, CALL);
      chk("call_flush", 32'(bus.flush), 32'h1);
      step();
      chk("call_pc", 32'(bus.pc), 32'h100);
      chk("call_cnt", 32'(bus.ras_count), 32'h1);
      drive(0, 0, ADD);
      step();
      chk("call_seq", 32'(bus.pc), 32'h101);
      drive(1, 0, RET);
      chk("ret_flush", 32'(bus.flush), 32'h1);
      step();
      chk("ret_pc", 32'(bus.pc), 32'h21);
      chk("ret_cnt", 32'(bus.ras_count), 32'h0);
      bus.branch_target = 16'h0005; drive(1, 1, BEQ);
      for (int i = 0; i < 2; i++) begin
         chk("stall_flush", 32'(bus.flush), 32'h0);
         step();
         chk("stall_pc", 32'(bus.pc), 32'h21);
      end
      drive(1, 0, BEQ);
      chk("rel_flush", 32'(bus.flush), 32'h1);
      step();
      chk("rel_pc", 32'(bus.pc), 32'h5);
      for (int i = 1; i <= 9; i++) begin
         bus.id_pc_plus1 = 16'(i); bus.jump_target = 16'(16'h0200 + i); drive(1, 0, CALL);
         step();
         chk("ovf_pc", 32'(bus.pc), 32'h200 + 32'(i));
         chk("ovf_cnt", 32'(bus.ras_count), (i > 8) ? 32'd8 : 32'(i));
         chk("ovf_flag", 32'(bus.ras_overflow), (i == 9) ? 32'h1 : 32'h0);
      end
      for (int i = 1; i <= 9; i++) begin
         drive(1, 0, RET);
         chk("unf_pre", 32'(bus.ras_underflow), 32'h0);
         step();
         chk("unf_pc", 32'(bus.pc), (i == 9) ? 32'h0 : 32'(10 - i));
         chk("unf_cnt", 32'(bus.ras_count), (i == 9) ? 32'h0 : 32'(8 - i));
      end
      chk("unf_flag", 32'(bus.ras_underflow), 32'h1);
      bus.jump_target = 16'hFFFF; drive(1, 0, JMP);
      step();
      chk("wrap_ffff", 32'(bus.pc), 32'hFFFF);
      drive(0, 0, ADD);
      step();
      chk("wrap_pc", 32'(bus.pc), 32'h0);
      drive(1, 0, ADD);
      chk("bad_flush", 32'(bus.flush), 32'h0);
      step();
      chk("bad_pc", 32'(bus.pc), 32'h1);
      chk("bad_flag", 32'(bus.bad_redirect), 32'h1);
      drive(0, 0, ADD);
      step();
      chk("bad_sticky", 32'(bus.bad_redirect), 32'h1);
      chk("bad_pc2", 32'(bus.pc), 32'h2);
      chk("ovf_sticky", 32'(bus.ras_overflow), 32'h1);
      rst = 1; bus.jump_target = 16'h0300; bus.id_pc_plus1 = 16'h0077; drive(1, 0, CALL);
      step();
      rst = 0;
      chk("rstmid_pc", 32'(bus.pc), 32'h0);
      chk("rstmid_cnt", 32'(bus.ras_count), 32'h0);
      chk("rstmid_flags", {29'b0, bus.ras_overflow, bus.ras_underflow, bus.bad_redirect}, 32'h0);
      drive(0, 0, ADD);
      step();
      chk("post_rst_pc", 32'(bus.pc), 32'h1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Fetch-side next-PC stage. It sits directly downstream of the decode-stage branch/jump resolver and consumes that block's `kill` request.
- Holds the architectural fetch PC and selects the next PC: sequential, branch target, jump target, or return address.
- Owns a circular return-address stack (RAS) for CALL/RET.
- Drives the IF/ID flush for redirected cycles.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; also the RET target on stack underflow.
- PC_INC, 1, sequential increment (word-addressed 16-bit instructions).
- RAS_DEPTH, 8, number of return-stack entries (power of two, ≥2).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- stall  input  1  data-hazard stall: hold PC, ignore kill.
- kill  input  1  redirect request from the decode-stage resolver.
- op  input  4  opcode of the instruction in ID (shared opcode constants).
- id_pc_plus1  input  16  PC+PC_INC of the instruction in ID (return address).
- branch_target  input  16  PC-relative target computed in ID (BEQ/BNE/FOR).
- jump_target  input  16  absolute target computed in ID (JMP/CALL).
- pc  output  16  current fetch PC (register).
- pc_plus1  output  16  pc + PC_INC, combinational.
- flush  output  1  clear IF/ID at this edge (combinational).
- ras_count  output  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_overflow  output  1  sticky: CALL pushed while full.
- ras_underflow  output  1  sticky: RET popped while empty.
- bad_redirect  output  1  sticky: kill with non-control opcode.

Behaviour:
- Reset: one clock, RST=1.
  - pc=RESET_PC, ras_count=0, stack pointer=0.
  - All sticky flags are 0.
  - Stack contents are don't-care.
- RST has priority over every other input.
- `redirect = kill & ~stall`. `flush = redirect & op ∈ {BEQ,BNE,JMP,CALL,RET,FOR}`.
- Update priority per edge (RST=0):
  1. stall=1: pc holds, no stack operation, kill ignored. The resolver re-evaluates with forwarded operands next cycle.
  2. redirect with BEQ, BNE or FOR: pc ← branch_target.
  3. redirect with JMP: pc ← jump_target.
  4. redirect with CALL: pc ← jump_target; push id_pc_plus1.
  5. redirect with RET: pc ← top of stack; pop.
  6. redirect with any other op: pc ← pc_plus1; flush=0; bad_redirect←1.
  7. Otherwise: pc ← pc_plus1.
- Latency: one cycle. The PC selected at edge N is presented on `pc` after edge N. flush is valid in the same cycle as kill.
- PC arithmetic is modulo 2^16: 16'hFFFF + 1 = 16'h0000. No overflow flag.
- RAS push when ras_count < RAS_DEPTH:
  - Write entry at sp, sp ← sp+1, count ← count+1.
- RAS push when full:
  - Overwrite the oldest entry (circular), sp ← sp+1, count stays RAS_DEPTH.
  - ras_overflow ← 1.
- RAS pop when count > 0:
  - Target = entry[sp-1], sp ← sp-1, count ← count-1.
- RAS pop when empty:
  - Target = RESET_PC, sp and count unchanged.
  - ras_underflow ← 1.
- Sticky flags clear only on RST.
- Reset mid-redirect: RST wins. No push or pop happens, and pc=RESET_PC.

Decomposition:
- Shared package/include (existing opcode header): opcode constants BEQ, BNE, JMP, CALL, RET, FOR.
- Also in the shared include: a PC_WIDTH=16 constant.
- Sub-module `return_stack` (params DEPTH, WIDTH):
  - Inputs: push, pop, push_data.
  - Outputs: top, count, overflow_evt, underflow_evt.
  - Holds the circular buffer and pointer arithmetic.
- pc_unit holds the PC register, next-PC mux and sticky flags.

Test Plan:
- Reset then 4 idle cycles (kill=0, stall=0) → pc = 0,1,2,3,4; flush=0 throughout; ras_count=0.
- pc=0x0010, kill=1, op=JMP, jump_target=0x0040 → flush=1 that cycle; next pc=0x0040; ras_count unchanged.
- CALL at id_pc_plus1=0x0021, target 0x0100; later RET with kill=1 → pc=0x0100, then 0x0021 after RET; ras_count 1→0.
- kill=1, op=BEQ, stall=1 for 2 cycles, then stall=0 with kill=1, branch_target=0x0005 → pc holds and flush=0 while stalled; pc=0x0005 after release.
- RAS_DEPTH=8: 9 CALLs with return addresses 0x1..0x9, then 9 RETs.
  - ras_overflow=1 after the 9th CALL.
  - RETs yield 0x9..0x2, and the 9th RET yields RESET_PC with ras_underflow=1.
- pc=0xFFFF, no redirect → pc=0x0000.
- kill=1, op=ADD → pc advances normally, flush=0, bad_redirect=1 until RST.
